// File: rtl/mips_pkg.sv
// mips_pkg: shared ALU op encoding, opcode/funct and stage constants, and control decode for the MIPS decode stage
package mips_pkg;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_MUL = 4'd7
  } alu_op_t;
  typedef enum logic [1:0] {DEST_RT, DEST_RD, DEST_RA} dest_sel_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_MUL   = 6'h1C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_MUL   = 6'h02;
  localparam logic [2:0] STAGE_FETCH  = 3'd0;
  localparam logic [2:0] STAGE_DECODE = 3'd1;
  localparam logic [2:0] STAGE_EXEC   = 3'd2;
  localparam logic [2:0] STAGE_MEM    = 3'd3;
  localparam logic [2:0] STAGE_WB     = 3'd4;
  localparam logic [4:0] LINK_REG = 5'd31;
  typedef struct packed {
    alu_op_t   alu_op;
    logic      alu_src;
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      branch_eq;
    logic      branch_ne;
    logic      jump;
    logic      link;
    logic      illegal;
    logic      zero_ext;
    dest_sel_t dest_sel;
  } ctrl_t;
  function automatic ctrl_t ctrl_decode(input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    c.alu_op = ALU_ADD;
    c.dest_sel = DEST_RT;
    case (op)
      OP_RTYPE: begin
        c.dest_sel = DEST_RD;
        c.reg_write = 1'b1;
        case (fn)
          FN_ADD:  c.alu_op = ALU_ADD;
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_SLT:  c.alu_op = ALU_SLT;
          FN_SLL:  c.alu_op = ALU_SLL;
          FN_SRL:  c.alu_op = ALU_SRL;
          default: c.illegal = 1'b1;
        endcase
      end
      OP_MUL: begin
        c.dest_sel = DEST_RD;
        c.reg_write = 1'b1;
        c.alu_op = ALU_MUL;
        c.illegal = fn != FN_MUL;
      end
      OP_ADDI: {c.alu_src, c.reg_write} = 2'b11;
      OP_SLTI: begin
        {c.alu_src, c.reg_write} = 2'b11;
        c.alu_op = ALU_SLT;
      end
      OP_ANDI: begin
        {c.alu_src, c.reg_write, c.zero_ext} = 3'b111;
        c.alu_op = ALU_AND;
      end
      OP_ORI: begin
        {c.alu_src, c.reg_write, c.zero_ext} = 3'b111;
        c.alu_op = ALU_OR;
      end
      OP_LW:  {c.alu_src, c.reg_write, c.mem_read} = 3'b111;
      OP_SW:  {c.alu_src, c.mem_write} = 2'b11;
      OP_BEQ: begin
        c.branch_eq = 1'b1;
        c.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        c.branch_ne = 1'b1;
        c.alu_op = ALU_SUB;
      end
      OP_J:   c.jump = 1'b1;
      OP_JAL: begin
        {c.jump, c.link, c.reg_write} = 3'b111;
        c.dest_sel = DEST_RA;
      end
      default: c.illegal = 1'b1;
    endcase
    // an illegal word must not disturb architectural state downstream
    if (c.illegal) begin
      c.reg_write = 1'b0;
      c.alu_op = ALU_ADD;
    end
    return c;
  endfunction
endpackage

// File: rtl/reg_file.sv
// reg_file: 32x32 register file, two combinational reads, one synchronous write, register 0 hardwired to zero
//   clock, reset_n : clock and synchronous active-low clear of every register
//   i_ra, i_rb     : read addresses; o_a, o_b: read data
//   i_we, i_wa, i_wd : write enable, address, data
module reg_file #(
  parameter int REG_COUNT = 32,
  parameter int DATA_W = 32,
  localparam int AW = $clog2(REG_COUNT)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [AW-1:0]     i_ra,
  input  logic [AW-1:0]     i_rb,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  input  logic              i_we,
  input  logic [AW-1:0]     i_wa,
  input  logic [DATA_W-1:0] i_wd
);
  logic [REG_COUNT-1:0][DATA_W-1:0] r_mem;
  always_ff @(posedge clock)
    if (!reset_n) r_mem <= '0;
    else if (i_we && i_wa != '0) r_mem[i_wa] <= i_wd;
  assign o_a = i_ra == '0 ? '0 : r_mem[i_ra];
  assign o_b = i_rb == '0 ? '0 : r_mem[i_rb];
endmodule

// File: rtl/decode.sv
// decode: MIPS decode stage; captures the instruction at stage 1, reads operands, latches fields and control
//   clock, reset_n        : clock and synchronous active-low reset
//   stage                 : shared stage counter (capture at 1, writeback at 4)
//   instr_in              : instruction word from fetch
//   wb_en/wb_addr/wb_data : register writeback request, honoured only at stage 4
//   outputs               : operands, immediate, fields and control, held from stage 2 until the next capture
module decode import mips_pkg::*; #(
  parameter int REG_COUNT = 32,
  parameter int DATA_W = 32,
  localparam int AW = $clog2(REG_COUNT)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [2:0]        stage,
  input  logic [DATA_W-1:0] instr_in,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] imm_ext,
  output logic [4:0]        shamt,
  output logic [AW-1:0]     dest_addr,
  output logic [25:0]       jump_target,
  output logic [3:0]        alu_op,
  output logic              alu_src,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch_eq,
  output logic              branch_ne,
  output logic              jump,
  output logic              link,
  output logic              illegal
);
  logic [DATA_W-1:0] w_rs_val, w_rt_val, w_imm;
  logic [AW-1:0] w_dest;
  ctrl_t w_ctrl;
  assign w_ctrl = ctrl_decode(instr_in[31:26], instr_in[5:0]);
  assign w_imm = w_ctrl.zero_ext ? {{(DATA_W-16){1'b0}}, instr_in[15:0]} : {{(DATA_W-16){instr_in[15]}}, instr_in[15:0]};
  assign w_dest = w_ctrl.dest_sel == DEST_RD ? instr_in[15:11] : w_ctrl.dest_sel == DEST_RA ? LINK_REG : instr_in[20:16];
  reg_file #(.REG_COUNT(REG_COUNT), .DATA_W(DATA_W)) u_rf (
    .clock  (clock),
    .reset_n(reset_n),
    .i_ra   (instr_in[25:21]),
    .i_rb   (instr_in[20:16]),
    .o_a    (w_rs_val),
    .o_b    (w_rt_val),
    .i_we   (stage == STAGE_WB && wb_en),
    .i_wa   (wb_addr),
    .i_wd   (wb_data)
  );
  always_ff @(posedge clock)
    if (!reset_n) begin
      {rs_data, rt_data, imm_ext, shamt, dest_addr, jump_target} <= '0;
      {alu_op, alu_src, reg_write, mem_read, mem_write} <= '0;
      {branch_eq, branch_ne, jump, link, illegal} <= '0;
    end else if (stage == STAGE_DECODE) begin
      rs_data <= w_rs_val;
      rt_data <= w_rt_val;
      imm_ext <= w_imm;
      shamt <= instr_in[10:6];
      dest_addr <= w_dest;
      jump_target <= instr_in[25:0];
      alu_op <= w_ctrl.alu_op;
      alu_src <= w_ctrl.alu_src;
      reg_write <= w_ctrl.reg_write;
      mem_read <= w_ctrl.mem_read;
      mem_write <= w_ctrl.mem_write;
      branch_eq <= w_ctrl.branch_eq;
      branch_ne <= w_ctrl.branch_ne;
      jump <= w_ctrl.jump;
      link <= w_ctrl.link;
      illegal <= w_ctrl.illegal;
    end
endmodule

// File: tb/tb_decode.sv
// tb_decode: table-driven scoreboard bench for the MIPS decode stage
module tb_decode;
  logic clock = 0, reset_n = 0, wb_en = 0;
  logic [2:0] stage = 0;
  logic [31:0] instr_in = 0, wb_data = 0;
  logic [4:0] wb_addr = 0;
  logic [31:0] rs_data, rt_data, imm_ext;
  logic [4:0] shamt, dest_addr;
  logic [25:0] jump_target;
  logic [3:0] alu_op;
  logic alu_src, reg_write, mem_read, mem_write, branch_eq, branch_ne, jump, link, illegal;
  decode dut (
    .clock(clock), .reset_n(reset_n), .stage(stage), .instr_in(instr_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext), .shamt(shamt),
    .dest_addr(dest_addr), .jump_target(jump_target), .alu_op(alu_op), .alu_src(alu_src),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch_eq(branch_eq), .branch_ne(branch_ne), .jump(jump), .link(link), .illegal(illegal)
  );
  always #5 clock = ~clock;
  typedef struct packed {
    logic [31:0] rs, rt, imm;
    logic [4:0] sh, dest;
    logic [25:0] jt;
    logic [3:0] op;
    logic src, rw, mr, mw, be, bn, j, lk, il;
  } obs_t;
  typedef struct {
    string name;
    logic [31:0] instr, imm;
    logic [4:0] dest;
    logic [3:0] op;
    logic [8:0] flags;
    logic dd, ds;
  } vec_t;
  typedef struct {
    string name;
    obs_t exp;
    logic dd, ds;
  } sb_t;
  vec_t vt[$];
  sb_t sbq[$];
  obs_t last;
  logic [31:0] model [32];
  int errors = 0, checks = 0;
  function automatic logic [31:0] rc(int rs, int rt, int rd, int sh, int fn);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction
  function automatic logic [31:0] ri(int op, int rs, int rt, int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction
  function automatic logic [31:0] sx(logic [31:0] x);
    return {{16{x[15]}}, x[15:0]};
  endfunction
  // flags order: alu_src reg_write mem_read mem_write beq bne jump link illegal
  function automatic vec_t mk(string n, logic [31:0] ins, logic [31:0] imm, logic [4:0] d, logic [3:0] op, logic [8:0] f, logic dd, logic ds);
    vec_t v;
    v.name = n; v.instr = ins; v.imm = imm; v.dest = d; v.op = op; v.flags = f; v.dd = dd; v.ds = ds;
    return v;
  endfunction
  function automatic obs_t sample();
    return {rs_data, rt_data, imm_ext, shamt, dest_addr, jump_target, alu_op, alu_src, reg_write,
            mem_read, mem_write, branch_eq, branch_ne, jump, link, illegal};
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic check(string name, obs_t exp, logic dd, logic ds);
    obs_t a;
    a = sample();
    if (dd) a.dest = exp.dest;
    if (ds) a.src = exp.src;
    checks++;
    if (a !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, sample(), exp);
    end
  endtask
  task automatic check_pop();
    sb_t e;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sbq.pop_front();
      last = e.exp;
      check(e.name, e.exp, e.dd, e.ds);
    end
  endtask
  task automatic run_decode(vec_t v);
    sb_t e;
    stage = 3'd1;
    instr_in = v.instr;
    e.name = v.name; e.dd = v.dd; e.ds = v.ds;
    e.exp = {model[v.instr[25:21]], model[v.instr[20:16]], v.imm, v.instr[10:6], v.dest,
             v.instr[25:0], v.op, v.flags};
    sbq.push_back(e);
    tick();
    stage = 3'd2;
    instr_in = $urandom;
    check_pop();
  endtask
  task automatic wb(logic [4:0] a, logic [31:0] d, logic [2:0] stg);
    stage = stg; wb_en = 1; wb_addr = a; wb_data = d;
    if (stg == 3'd4 && a != 0) model[a] = d;
    tick();
    wb_en = 0; stage = 3'd0;
  endtask
  initial begin
    foreach (model[i]) model[i] = 0;
    vt.push_back(mk("add", 32'h00A6_3820, sx(32'h3820), 7, 0, 9'b0_1_0_0_0_0_0_0_0, 0, 0));
    vt.push_back(mk("add_r0", rc(0, 6, 7, 0, 'h20), sx(rc(0, 6, 7, 0, 'h20)), 7, 0, 9'b0_1_0_0_0_0_0_0_0, 0, 0));
    vt.push_back(mk("add_gated", rc(2, 1, 4, 0, 'h20), sx(rc(2, 1, 4, 0, 'h20)), 4, 0, 9'b0_1_0_0_0_0_0_0_0, 0, 0));
    vt.push_back(mk("sub", rc(1, 5, 3, 0, 'h22), sx(rc(1, 5, 3, 0, 'h22)), 3, 1, 9'b0_1_0_0_0_0_0_0_0, 0, 0));
    vt.push_back(mk("and", rc(5, 6, 4, 0, 'h24), sx(rc(5, 6, 4, 0, 'h24)), 4, 2, 9'b0_1_0_0_0_0_0_0_0, 0, 0));
    vt.push_back(mk("or", rc(5, 6, 4, 0, 'h25), sx(rc(5, 6, 4, 0, 'h25)), 4, 3, 9'b0_1_0_0_0_0_0_0_0, 0, 0));
    vt.push_back(mk("slt", rc(1, 5, 8, 0, 'h2A), sx(rc(1, 5, 8, 0, 'h2A)), 8, 4, 9'b0_1_0_0_0_0_0_0_0, 0, 0));
    vt.push_back(mk("sll", rc(0, 5, 9, 3, 'h00), sx(rc(0, 5, 9, 3, 'h00)), 9, 5, 9'b0_1_0_0_0_0_0_0_0, 0, 0));
    vt.push_back(mk("srl", rc(0, 6, 10, 31, 'h02), sx(rc(0, 6, 10, 31, 'h02)), 10, 6, 9'b0_1_0_0_0_0_0_0_0, 0, 0));
    vt.push_back(mk("mul", {6'h1C, 5'd5, 5'd6, 5'd11, 5'd0, 6'h02}, 32'h0000_5802, 11, 7, 9'b0_1_0_0_0_0_0_0_0, 0, 1));
    vt.push_back(mk("addi", ri('h08, 1, 12, 'hFFFC), 32'hFFFF_FFFC, 12, 0, 9'b1_1_0_0_0_0_0_0_0, 0, 0));
    vt.push_back(mk("slti", ri('h0A, 5, 13, 'h8000), 32'hFFFF_8000, 13, 4, 9'b1_1_0_0_0_0_0_0_0, 0, 0));
    vt.push_back(mk("andi", ri('h0C, 1, 14, 'h8001), 32'h0000_8001, 14, 2, 9'b1_1_0_0_0_0_0_0_0, 0, 0));
    vt.push_back(mk("ori", ri('h0D, 5, 15, 'hFFFC), 32'h0000_FFFC, 15, 3, 9'b1_1_0_0_0_0_0_0_0, 0, 0));
    vt.push_back(mk("lw", ri('h23, 1, 16, 'h0004), 32'h0000_0004, 16, 0, 9'b1_1_1_0_0_0_0_0_0, 0, 0));
    vt.push_back(mk("sw", ri('h2B, 1, 5, 'hFFF8), 32'hFFFF_FFF8, 0, 0, 9'b1_0_0_1_0_0_0_0_0, 1, 0));
    vt.push_back(mk("beq", ri('h04, 5, 6, 'h0003), 32'h0000_0003, 0, 1, 9'b0_0_0_0_1_0_0_0_0, 1, 0));
    vt.push_back(mk("bne", ri('h05, 1, 6, 'h8000), 32'hFFFF_8000, 0, 1, 9'b0_0_0_0_0_1_0_0_0, 1, 0));
    vt.push_back(mk("j", {6'h02, 26'h123_4567}, 32'h0000_4567, 0, 0, 9'b0_0_0_0_0_0_1_0_0, 1, 1));
    vt.push_back(mk("jal", 32'h0C00_0009, 32'h0000_0009, 31, 0, 9'b0_1_0_0_0_0_1_1_0, 0, 1));
    vt.push_back(mk("ill_op", ri('h3F, 1, 2, 'hFFFF), 32'hFFFF_FFFF, 0, 0, 9'b0_0_0_0_0_0_0_0_1, 1, 1));
    vt.push_back(mk("ill_fn", rc(5, 6, 7, 0, 'h3F), sx(rc(5, 6, 7, 0, 'h3F)), 0, 0, 9'b0_0_0_0_0_0_0_0_1, 1, 1));
    vt.push_back(mk("ill_mul", {6'h1C, 5'd5, 5'd6, 5'd11, 5'd0, 6'h20}, 32'h0000_5820, 0, 0, 9'b0_0_0_0_0_0_0_0_1, 1, 1));
    tick();
    tick();
    check("reset", '0, 0, 0);
    reset_n = 1;
    run_decode(mk("rd_zero", rc(31, 17, 3, 0, 'h20), sx(rc(31, 17, 3, 0, 'h20)), 3, 0, 9'b0_1_0_0_0_0_0_0_0, 0, 0));
    wb(5, 32'h0000_0007, 4);
    wb(6, 32'h0000_0010, 4);
    wb(1, 32'hFFFF_FFF0, 4);
    wb(0, 32'hFFFF_FFFF, 4);
    wb(6, 32'h0000_DEAD, 2);
    wb(1, 32'h0000_1234, 3);
    wb(2, 32'h0000_0099, 5);
    wb(2, 32'h0000_0099, 0);
    wb(2, 32'h0000_0099, 7);
    foreach (vt[i]) run_decode(vt[i]);
    run_decode(vt[0]);
    for (int s = 2; s < 8; s++) begin
      stage = s[2:0];
      instr_in = $urandom;
      tick();
      check($sformatf("hold_s%0d", s), last, 0, 0);
    end
    stage = 3'd4; wb_en = 1; wb_addr = 5; wb_data = 32'h0000_0055; reset_n = 0;
    tick();
    check("rst_wb", '0, 0, 0);
    reset_n = 1; wb_en = 0; stage = 3'd0;
    foreach (model[i]) model[i] = 0;
    run_decode(vt[0]);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d leftover expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
